// File: rtl/axi_bw_allocator_err.sv
// B-channel allocator for one slave port: round-robin merge of N_INIT_PORT
// response sources, outstanding-write tracking, and DECERR generation for
// writes to unmapped addresses. The W burst of such a write is sunk here, and
// its error B is issued only after all earlier writes have returned their B.
module axi_bw_allocator_err #(
    parameter int unsigned AXI_USER_W  = 6,
    parameter int unsigned N_INIT_PORT = 4,
    parameter int unsigned N_TARG_PORT = 7,
    parameter int unsigned AXI_ID_IN   = 16,
    parameter int unsigned AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
    parameter int unsigned CNT_W       = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    output logic [AXI_ID_IN-1:0]              bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    input  logic                              incr_req_i,
    output logic                              full_counter_o,
    output logic                              outstanding_trans_o,
    input  logic                              error_req_i,
    output logic                              error_gnt_o,
    input  logic [AXI_USER_W-1:0]             error_user_i,
    input  logic [AXI_ID_IN-1:0]              error_id_i,
    input  logic                              sample_awdata_info_i,
    input  logic                              err_wvalid_i,
    input  logic                              err_wlast_i,
    output logic                              err_wready_o
);

    localparam int unsigned PTR_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DRAIN = 2'd1,
        SINK_W     = 2'd2,
        SEND_B     = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [AXI_USER_W-1:0]   error_user_q;
    logic [AXI_ID_IN-1:0]    error_id_q;

    logic                    arb_en;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    any_valid;
    logic                    norm_valid;
    logic                    norm_hs;

    logic [AXI_ID_IN-1:0]    bid_arr   [N_INIT_PORT];
    logic [1:0]              bresp_arr [N_INIT_PORT];
    logic [AXI_USER_W-1:0]   buser_arr [N_INIT_PORT];

    // Routing bits above AXI_ID_IN are intentionally dropped.
    logic unused_bid_bits;
    assign unused_bid_bits = ^bid_i;

    // Split the flat source buses into per-port fields, keeping only the low ID bits.
    for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_split
        assign bid_arr[p]   = bid_i[p*AXI_ID_OUT +: AXI_ID_IN];
        assign bresp_arr[p] = bresp_i[p*2 +: 2];
        assign buser_arr[p] = buser_i[p*AXI_USER_W +: AXI_USER_W];
    end

    assign arb_en     = (state_q == IDLE) || (state_q == WAIT_DRAIN);
    assign norm_valid = any_valid & arb_en;
    assign norm_hs    = norm_valid & bready_i;

    if (N_INIT_PORT == 1) begin : g_single
        // Single source: direct binding, nothing to arbitrate.
        assign gnt_idx   = '0;
        assign any_valid = bvalid_i[0];
    end else begin : g_rr
        logic [PTR_W-1:0] rr_q;
        logic             lock_q;
        logic [PTR_W-1:0] lock_idx_q;
        logic [PTR_W-1:0] scan_idx;
        logic             scan_found;

        // First valid source at or above the RR pointer, wrapping around.
        always_comb begin
            int unsigned idx;
            idx        = 0;
            scan_idx   = rr_q;
            scan_found = 1'b0;
            for (int unsigned i = 0; i < N_INIT_PORT; i++) begin
                idx = (32'(rr_q) + i) % N_INIT_PORT;
                if (!scan_found && bvalid_i[PTR_W'(idx)]) begin
                    scan_found = 1'b1;
                    scan_idx   = PTR_W'(idx);
                end
            end
        end

        // A pending, unaccepted response pins the grant so the B payload stays stable.
        assign gnt_idx   = lock_q ? lock_idx_q : scan_idx;
        assign any_valid = lock_q ? bvalid_i[lock_idx_q] : scan_found;

        // RR pointer advances past the winner on handshake; lock tracks stalled grants.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_q       <= '0;
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
            end else if (norm_hs) begin
                rr_q   <= (gnt_idx == PTR_W'(N_INIT_PORT - 1)) ? '0 : gnt_idx + PTR_W'(1);
                lock_q <= 1'b0;
            end else if (norm_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= gnt_idx;
            end
        end
    end

    // Merged B channel: error response in SEND_B, else the granted source.
    always_comb begin
        bvalid_o = 1'b0;
        bresp_o  = 2'b00;
        bid_o    = '0;
        buser_o  = '0;
        bready_o = '0;
        if (state_q == SEND_B) begin
            bvalid_o = 1'b1;
            bresp_o  = 2'b11;
            bid_o    = error_id_q;
            buser_o  = error_user_q;
        end else if (norm_valid) begin
            bvalid_o          = 1'b1;
            bresp_o           = bresp_arr[gnt_idx];
            bid_o             = bid_arr[gnt_idx];
            buser_o           = buser_arr[gnt_idx];
            bready_o[gnt_idx] = bready_i;
        end
    end

    // Outstanding-write counter; saturates at both ends, error B never decrements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            case ({incr_req_i, norm_hs})
                2'b10:   if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign outstanding_trans_o = (cnt_q != '0);
    assign full_counter_o      = (cnt_q == '1);

    // Capture AW info of the write that will receive DECERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_user_q <= '0;
            error_id_q   <= '0;
        end else if (sample_awdata_info_i) begin
            error_user_q <= error_user_i;
            error_id_q   <= error_id_i;
        end
    end

    // Error sequencing: drain earlier writes, sink W, then send the DECERR B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (error_req_i) state_q <= outstanding_trans_o ? WAIT_DRAIN : SINK_W;
                end
                WAIT_DRAIN: begin
                    if (cnt_q == '0) state_q <= SINK_W;
                end
                SINK_W: begin
                    if (err_wvalid_i && err_wlast_i) state_q <= SEND_B;
                end
                SEND_B: begin
                    if (bready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_wready_o = (state_q == SINK_W);
    assign error_gnt_o  = (state_q == SEND_B) && bready_i;

endmodule

// File: tb/tb_axi_bw_allocator_err.sv
// Directed bench for axi_bw_allocator_err with N_INIT_PORT=4.
module tb_axi_bw_allocator_err;

    localparam int unsigned UW   = 6;
    localparam int unsigned NI   = 4;
    localparam int unsigned IDI  = 16;
    localparam int unsigned IDO  = 19;

    logic                 clk;
    logic                 rst_n;
    logic [NI*IDO-1:0]    bid_i;
    logic [NI*2-1:0]      bresp_i;
    logic [NI*UW-1:0]     buser_i;
    logic [NI-1:0]        bvalid_i;
    logic [NI-1:0]        bready_o;
    logic [IDI-1:0]       bid_o;
    logic [1:0]           bresp_o;
    logic [UW-1:0]        buser_o;
    logic                 bvalid_o;
    logic                 bready_i;
    logic                 incr_req_i;
    logic                 full_counter_o;
    logic                 outstanding_trans_o;
    logic                 error_req_i;
    logic                 error_gnt_o;
    logic [UW-1:0]        error_user_i;
    logic [IDI-1:0]       error_id_i;
    logic                 sample_awdata_info_i;
    logic                 err_wvalid_i;
    logic                 err_wlast_i;
    logic                 err_wready_o;

    int checks = 0;
    int errors = 0;

    axi_bw_allocator_err #(
        .AXI_USER_W (UW),
        .N_INIT_PORT(NI),
        .N_TARG_PORT(7),
        .AXI_ID_IN  (IDI),
        .AXI_ID_OUT (IDO),
        .CNT_W      (10)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bid_i               (bid_i),
        .bresp_i             (bresp_i),
        .buser_i             (buser_i),
        .bvalid_i            (bvalid_i),
        .bready_o            (bready_o),
        .bid_o               (bid_o),
        .bresp_o             (bresp_o),
        .buser_o             (buser_o),
        .bvalid_o            (bvalid_o),
        .bready_i            (bready_i),
        .incr_req_i          (incr_req_i),
        .full_counter_o      (full_counter_o),
        .outstanding_trans_o (outstanding_trans_o),
        .error_req_i         (error_req_i),
        .error_gnt_o         (error_gnt_o),
        .error_user_i        (error_user_i),
        .error_id_i          (error_id_i),
        .sample_awdata_info_i(sample_awdata_info_i),
        .err_wvalid_i        (err_wvalid_i),
        .err_wlast_i         (err_wlast_i),
        .err_wready_o        (err_wready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port_id(input int p);
        return 32'(16'hA000 | 16'(p));
    endfunction

    initial begin
        rst_n = 1'b0;
        bvalid_i = '0; bready_i = 1'b0; incr_req_i = 1'b0;
        error_req_i = 1'b0; error_user_i = '0; error_id_i = '0;
        sample_awdata_info_i = 1'b0; err_wvalid_i = 1'b0; err_wlast_i = 1'b0;
        for (int p = 0; p < int'(NI); p++) begin
            bid_i[p*IDO +: IDO]  = {3'b101, 16'hA000 | 16'(p)};
            bresp_i[p*2 +: 2]    = 2'(p % 2);
            buser_i[p*UW +: UW]  = 6'(p + 8);
        end

        // Reset state
        cyc(); cyc();
        chk("rst_bvalid", 32'(bvalid_o), 0);
        chk("rst_bready", 32'(bready_o), 0);
        chk("rst_wready", 32'(err_wready_o), 0);
        chk("rst_gnt", 32'(error_gnt_o), 0);
        chk("rst_outst", 32'(outstanding_trans_o), 0);
        chk("rst_full", 32'(full_counter_o), 0);
        rst_n = 1'b1;
        cyc();

        // Round-robin fairness with 4 outstanding writes preloaded
        incr_req_i = 1'b1;
        repeat (4) cyc();
        incr_req_i = 1'b0;
        #1;
        chk("rr_outst_pre", 32'(outstanding_trans_o), 1);
        bvalid_i = 4'hF; bready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_bready", 32'(bready_o), 32'(4'b0001 << (k % 4)));
            chk("rr_bid", 32'(bid_o), port_id(k % 4));
            chk("rr_bresp", 32'(bresp_o), 32'((k % 4) % 2));
            if (k == 4) chk("rr_outst_zero", 32'(outstanding_trans_o), 0);
            cyc();
        end
        chk("rr_decr_at_zero", 32'(outstanding_trans_o), 0);
        bvalid_i = '0;

        // Stability: put RR pointer at 3 via a handshake on port 2, then stall port 2
        bvalid_i = 4'b0100; bready_i = 1'b1;
        #1;
        chk("st_pre_bready", 32'(bready_o), 32'(4'b0100));
        cyc();
        bready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_hold_bid", 32'(bid_o), port_id(2));
            chk("st_hold_valid", 32'(bvalid_o), 1);
            chk("st_hold_bready", 32'(bready_o), 0);
            cyc();
        end
        bvalid_i = 4'b0101;
        #1;
        chk("st_locked_bid", 32'(bid_o), port_id(2));
        cyc();
        bready_i = 1'b1;
        #1;
        chk("st_locked_bready", 32'(bready_o), 32'(4'b0100));
        chk("st_locked_bid2", 32'(bid_o), port_id(2));
        cyc();
        bvalid_i = 4'b0001;
        #1;
        chk("st_next_bready", 32'(bready_o), 32'(4'b0001));
        chk("st_next_bid", 32'(bid_o), port_id(0));
        cyc();
        bvalid_i = '0; bready_i = 1'b0;

        // Error with nothing outstanding
        error_req_i = 1'b1; sample_awdata_info_i = 1'b1;
        error_id_i = 16'h00A5; error_user_i = 6'h15;
        #1;
        chk("e1_idle_wready", 32'(err_wready_o), 0);
        cyc();
        sample_awdata_info_i = 1'b0; error_id_i = 16'hFFFF; error_user_i = 6'h3F;
        bvalid_i = 4'b0010; bready_i = 1'b1;
        err_wvalid_i = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            err_wlast_i = (b == 4);
            if (b == 4) bvalid_i = '0;
            #1;
            chk("e1_sink_wready", 32'(err_wready_o), 1);
            chk("e1_sink_bvalid", 32'(bvalid_o), 0);
            chk("e1_sink_bready", 32'(bready_o), 0);
            cyc();
        end
        err_wvalid_i = 1'b0; err_wlast_i = 1'b0; bready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("e1_b_valid", 32'(bvalid_o), 1);
            chk("e1_b_resp", 32'(bresp_o), 3);
            chk("e1_b_id", 32'(bid_o), 32'h00A5);
            chk("e1_b_user", 32'(buser_o), 32'h15);
            chk("e1_b_wready", 32'(err_wready_o), 0);
            chk("e1_b_gnt_wait", 32'(error_gnt_o), 0);
            cyc();
        end
        bready_i = 1'b1;
        #1;
        chk("e1_gnt", 32'(error_gnt_o), 1);
        chk("e1_gnt_bready", 32'(bready_o), 0);
        cyc();
        error_req_i = 1'b0;
        #1;
        chk("e1_gnt_pulse", 32'(error_gnt_o), 0);
        chk("e1_after_bvalid", 32'(bvalid_o), 0);
        chk("e1_outst", 32'(outstanding_trans_o), 0);
        bready_i = 1'b0;

        // Error behind two outstanding writes (RR pointer now at 1)
        incr_req_i = 1'b1;
        repeat (2) cyc();
        incr_req_i = 1'b0;
        error_req_i = 1'b1; sample_awdata_info_i = 1'b1;
        error_id_i = 16'h0033; error_user_i = 6'h2A;
        cyc();
        sample_awdata_info_i = 1'b0;
        bvalid_i = 4'b0001; bready_i = 1'b1;
        #1;
        chk("e2_drain_b0_valid", 32'(bvalid_o), 1);
        chk("e2_drain_b0_resp", 32'(bresp_o), 0);
        chk("e2_drain_b0_id", 32'(bid_o), port_id(0));
        chk("e2_drain_wready", 32'(err_wready_o), 0);
        cyc();
        bvalid_i = 4'b0010;
        #1;
        chk("e2_drain_b1_id", 32'(bid_o), port_id(1));
        chk("e2_drain_b1_resp", 32'(bresp_o), 1);
        cyc();
        bvalid_i = '0;
        #1;
        chk("e2_drained_outst", 32'(outstanding_trans_o), 0);
        chk("e2_drained_wready", 32'(err_wready_o), 0);
        cyc();
        chk("e2_sink_wready", 32'(err_wready_o), 1);
        err_wvalid_i = 1'b1; err_wlast_i = 1'b1;
        cyc();
        err_wvalid_i = 1'b0; err_wlast_i = 1'b0;
        chk("e2_b_resp", 32'(bresp_o), 3);
        chk("e2_b_id", 32'(bid_o), 32'h0033);
        chk("e2_b_user", 32'(buser_o), 32'h2A);
        chk("e2_gnt", 32'(error_gnt_o), 1);
        cyc();
        error_req_i = 1'b0; bready_i = 1'b0;

        // Counter saturation edges
        incr_req_i = 1'b1;
        repeat (1023) cyc();
        chk("cnt_full", 32'(full_counter_o), 1);
        cyc();
        chk("cnt_full_hold", 32'(full_counter_o), 1);
        bvalid_i = 4'b0001; bready_i = 1'b1;
        cyc();
        chk("cnt_incr_decr_hold", 32'(full_counter_o), 1);
        incr_req_i = 1'b0;
        cyc();
        chk("cnt_decr_full", 32'(full_counter_o), 0);
        chk("cnt_decr_outst", 32'(outstanding_trans_o), 1);
        repeat (1021) cyc();
        chk("cnt_one_left", 32'(outstanding_trans_o), 1);
        cyc();
        chk("cnt_zero", 32'(outstanding_trans_o), 0);
        cyc();
        chk("cnt_zero_hold_outst", 32'(outstanding_trans_o), 0);
        chk("cnt_zero_hold_full", 32'(full_counter_o), 0);
        bvalid_i = '0; bready_i = 1'b0;

        // Reset during the W sink, then a fresh error transaction
        error_req_i = 1'b1; sample_awdata_info_i = 1'b1;
        error_id_i = 16'h0077; error_user_i = 6'h07;
        cyc();
        sample_awdata_info_i = 1'b0;
        err_wvalid_i = 1'b1; err_wlast_i = 1'b0;
        repeat (2) cyc();
        chk("rs_mid_wready", 32'(err_wready_o), 1);
        rst_n = 1'b0; error_req_i = 1'b0; err_wvalid_i = 1'b0;
        #1;
        chk("rs_wready", 32'(err_wready_o), 0);
        chk("rs_bvalid", 32'(bvalid_o), 0);
        chk("rs_gnt", 32'(error_gnt_o), 0);
        chk("rs_outst", 32'(outstanding_trans_o), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rs_idle_wready", 32'(err_wready_o), 0);
        chk("rs_idle_bvalid", 32'(bvalid_o), 0);
        error_req_i = 1'b1;
        cyc();
        chk("rs_new_sink", 32'(err_wready_o), 1);
        err_wvalid_i = 1'b1; err_wlast_i = 1'b1;
        cyc();
        err_wvalid_i = 1'b0; err_wlast_i = 1'b0;
        chk("rs_new_resp", 32'(bresp_o), 3);
        chk("rs_new_id_cleared", 32'(bid_o), 0);
        chk("rs_new_user_cleared", 32'(buser_o), 0);
        bready_i = 1'b1;
        #1;
        chk("rs_new_gnt", 32'(error_gnt_o), 1);
        cyc();
        error_req_i = 1'b0; bready_i = 1'b0;
        #1;
        chk("rs_new_done", 32'(bvalid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bw_allocator_err.md
Name: axi_bw_allocator_err

Overview:
- Write-response (B) channel allocator for one slave port of the AXI node; the write-direction counterpart of the read-response allocator.
- Merges B responses from N_INIT_PORT master-side ports into one B channel using a round-robin arbiter, and strips routing bits from the ID.
- Tracks outstanding write transactions.
- For writes to unmapped addresses, it sinks the W burst and returns a DECERR B response once all earlier writes have completed.

Parameters:
- AXI_USER_W, 6, user signal width
- N_INIT_PORT, 4, number of B sources (1 allowed: direct binding, no arbitration)
- N_TARG_PORT, 7, slave ports of the node
- AXI_ID_IN, 16, ID width at slave port
- AXI_ID_OUT, AXI_ID_IN+$clog2(N_TARG_PORT), ID width at the B sources
- CNT_W, 10, outstanding counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bid_i  in  N_INIT_PORT*AXI_ID_OUT  B IDs; low AXI_ID_IN bits per port are forwarded
- bresp_i  in  N_INIT_PORT*2  B responses
- buser_i  in  N_INIT_PORT*AXI_USER_W  B user
- bvalid_i  in  N_INIT_PORT  B valid
- bready_o  out  N_INIT_PORT  B ready (one-hot grant)
- bid_o  out  AXI_ID_IN  merged B ID
- bresp_o  out  2  merged response
- buser_o  out  AXI_USER_W  merged user
- bvalid_o  out  1  merged valid
- bready_i  in  1  merged ready
- incr_req_i  in  1  accepted AW forwarded to a target (+1 outstanding)
- full_counter_o  out  1  outstanding counter at all-ones
- outstanding_trans_o  out  1  outstanding counter nonzero
- error_req_i  in  1  decode-error write pending
- error_gnt_o  out  1  one-cycle pulse: error B accepted
- error_user_i  in  AXI_USER_W  AW user of the errored write
- error_id_i  in  AXI_ID_IN  AW ID of the errored write
- sample_awdata_info_i  in  1  capture error_user_i/error_id_i
- err_wvalid_i  in  1  W beat of errored burst valid
- err_wlast_i  in  1  last W beat of errored burst
- err_wready_o  out  1  W sink ready

Behaviour:
- Reset values:
  - all outputs 0.
  - FSM state IDLE.
  - outstanding counter 0.
  - RR pointer 0.
  - lock flag 0.
  - captured error user/ID 0.
- Reset mid-burst aborts immediately to the reset state, with no pending error and no partial B.
- Capture: on a rising edge with sample_awdata_info_i=1, error_user_S<=error_user_i and error_id_S<=error_id_i; otherwise these registers hold.
- Arbiter:
  - Grant goes to the first set bvalid_i scanning from RR pointer upward, with wrap.
  - bvalid_o = (any bvalid_i) & arbiter enabled.
  - bready_o[g] = bready_i & enabled; all other bready_o bits are 0.
  - Outputs (bid/bresp/buser) come from the granted port, combinationally (0 latency).
  - If bvalid_o=1 and bready_i=0, the grant is locked until the handshake completes, so the selection cannot change while valid is pending (AXI stability).
  - On handshake, RR pointer <= (g+1) mod N_INIT_PORT and the lock clears.
  - Arbiter enabled only in IDLE and WAIT_DRAIN.
- Outstanding counter (CNT_W bits):
  - decr = normal B handshake; error B does not decrement.
  - incr only: +1, saturating at all-ones.
  - decr only: -1, saturating at 0.
  - incr and decr together: hold.
  - outstanding_trans_o = (cnt != 0); full_counter_o = (cnt == all-ones).
- FSM states: IDLE, WAIT_DRAIN, SINK_W, SEND_B.
- IDLE:
  - error_req_i=1 and outstanding_trans_o=0 -> SINK_W.
  - error_req_i=1 and outstanding_trans_o=1 -> WAIT_DRAIN.
  - otherwise stay in IDLE.
- WAIT_DRAIN: normal B traffic continues; move to SINK_W in the cycle after the counter reaches 0.
- SINK_W:
  - err_wready_o=1; W data is discarded.
  - Each err_wvalid_i beat is accepted.
  - Beat with err_wlast_i=1 -> SEND_B.
  - All bready_o=0 and bvalid_o=0.
- SEND_B:
  - bvalid_o=1, bresp_o=2'b11, bid_o=error_id_S, buser_o=error_user_S.
  - All bready_o=0.
  - bready_i=1: error_gnt_o=1 for that cycle, then -> IDLE.
  - Otherwise hold all B outputs stable.
- err_wready_o is 0 in every state except SINK_W.
- error_req_i must stay high until error_gnt_o.
- incr_req_i is honoured in all states.
- N_INIT_PORT=1: bypass the arbiter; the FSM and counter are unchanged.

Test Plan:
- RR fairness: N=4, bvalid_i=4'b1111 held, bready_i=1 -> grants in order 0,1,2,3,0; bid_o equals the low 16 bits of each port's bid_i; the counter, preloaded with 4 incr, reaches 0 after the 4th handshake.
- Stability: port2 valid with bready_i=0 for 3 cycles, then port0 asserts -> bready_o/bid_o stay on port2 until handshake; port0 is served next.
- Error, idle: counter 0, error_req_i with id 0x00A5 and user 0x15 sampled, 4 W beats with last on the 4th -> err_wready_o high exactly in SINK_W; B = {resp 3, id 0x00A5, user 0x15}; error_gnt_o pulses once; counter stays 0.
- Error behind outstanding: 2 incr, then error_req_i -> FSM waits in WAIT_DRAIN through 2 normal B handshakes, then SINK_W; no error B precedes the normal ones.
- Counter edges: 1023 incr -> full_counter_o=1, further incr holds at 1023; simultaneous incr+decr holds; decr at 0 stays 0.
- Reset mid-SINK_W after 2 beats -> all outputs 0 and FSM in IDLE; a new error transaction completes normally.
